seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 7-segment scan driver (option: SEG7_LEADING_ZERO_BLANK_EN)
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [TW-1:0]           timer, timer_n;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val, disp_val_n;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, disp_dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    wrap;
  logic                    suppress;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Next state, slot timing, display commit at the frame wrap, and the output image for the next cycle
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    timer_n    = timer;
    disp_val_n = disp_val;
    disp_dp_n  = disp_dp;
    wrap       = 1'b0;
    an_n       = '1;
    seg_n      = 7'h7F;
    dp_n       = 1'b1;
    suppress   = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          disp_val_n = value;
          disp_dp_n  = dp_in;
        end
        if (enable) begin
          state_n = SHOW;
          idx_n   = '0;
          timer_n = '0;
        end
      end
      SHOW, BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          timer_n = '0;
        end else if (state == SHOW && timer != SHOW_LAST) begin
          timer_n = timer + 1'b1;
        end else if (state == BLANK && timer != BLANK_LAST) begin
          timer_n = timer + 1'b1;
        end else if (state == SHOW && BLANK_CYCLES > 0) begin
          state_n = BLANK;
          timer_n = '0;
        end else begin
          // Slot finished: advance to the next digit; the last digit wraps and commits the staged value
          state_n = SHOW;
          timer_n = '0;
          if (idx == LAST_IDX) begin
            idx_n      = '0;
            wrap       = 1'b1;
            disp_val_n = load ? value : pend_val;
            disp_dp_n  = load ? dp_in : pend_dp;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        timer_n = '0;
      end
    endcase

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    suppress = (idx_n != '0) && !disp_dp_n[idx_n] && ((disp_val_n >> (4 * idx_n)) == '0);
`else
    suppress = 1'b0;
`endif

    if (state_n == SHOW && !suppress) begin
      an_n[idx_n] = 1'b0;
      seg_n       = hex7(disp_val_n[idx_n*4 +: 4]);
      dp_n        = ~disp_dp_n[idx_n];
    end
  end

  // State, staging/display registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      disp_val   <= disp_val_n;
      disp_dp    <= disp_dp_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_done <= wrap;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, frame_done, frame_done2;

  int    n_checks = 0;
  int    n_fail = 0;
  string phase = "";

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .load(load), .value(value), .dp_in(dp_in),
    .an(an2), .seg(seg2), .dp(dp2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit suppressed(input logic [15:0] v, input logic [3:0] d, input int i);
    bit en = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    en = 1'b1;
`endif
    return en && (i != 0) && !d[i] && ((v >> (4 * i)) == 16'h0);
  endfunction

  // Runs ncyc cycles of a frame starting at its first edge, checking every output each cycle
  task automatic check_frame(input logic [15:0] ev, input logic [3:0] edp, input bit fd0,
                             input int ld_cyc, input logic [15:0] lv, input logic [3:0] ldp,
                             input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int slot, pos;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      if (c == ld_cyc) begin
        load = 1'b1;
        value = lv;
        dp_in = ldp;
      end else begin
        load = 1'b0;
      end
      step();
      slot  = c / (R + B);
      pos   = c % (R + B);
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (pos < R && !suppressed(ev, edp, slot)) begin
        e_an[slot] = 1'b0;
        e_seg = seg_tab[(ev >> (4 * slot)) & 16'hF];
        e_dp  = ~edp[slot];
      end
      check($sformatf("c%0d an", c), 32'(an), 32'(e_an));
      check($sformatf("c%0d seg", c), 32'(seg), 32'(e_seg));
      check($sformatf("c%0d dp", c), 32'(dp), 32'(e_dp));
      check($sformatf("c%0d frame_done", c), 32'(frame_done), 32'(fd0 && c == 0));
    end
    load = 1'b0;
  endtask

  initial begin
    phase = "reset";
    step();
    step();
    check("an", 32'(an), 32'hF);
    check("seg", 32'(seg), 32'h7F);
    check("dp", 32'(dp), 32'h1);
    check("frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    reset2 = 1'b0;

    phase = "idle_load";
    load = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0000;
    step();
    load = 1'b0;
    step();
    check("an", 32'(an), 32'hF);
    check("seg", 32'(seg), 32'h7F);

    phase = "first_frames";
    enable = 1'b1;
    check_frame(16'h1234, 4'b0000, 1'b0, -1, 16'h0, 4'b0, 24);
    check_frame(16'h1234, 4'b0000, 1'b1, -1, 16'h0, 4'b0, 24);

    phase = "tear_free";
    check_frame(16'h1234, 4'b0000, 1'b1, 7, 16'hABCD, 4'b0000, 24);
    check_frame(16'hABCD, 4'b0000, 1'b1, -1, 16'h0, 4'b0, 24);
    phase = "wrap_load";
    check_frame(16'h9876, 4'b0000, 1'b1, 0, 16'h9876, 4'b0000, 24);

    phase = "dp_stage";
    check_frame(16'h9876, 4'b0000, 1'b1, 3, 16'h1234, 4'b0100, 24);
    phase = "dp_show";
    check_frame(16'h1234, 4'b0100, 1'b1, -1, 16'h0, 4'b0, 14);
    phase = "disable";
    enable = 1'b0;
    step();
    check("an", 32'(an), 32'hF);
    check("seg", 32'(seg), 32'h7F);
    check("dp", 32'(dp), 32'h1);
    check("frame_done", 32'(frame_done), 32'h0);
    step();
    check("an_hold", 32'(an), 32'hF);
    phase = "reenable";
    enable = 1'b1;
    check_frame(16'h1234, 4'b0100, 1'b0, -1, 16'h0, 4'b0, 24);

    phase = "lead_zero";
    check_frame(16'h1234, 4'b0100, 1'b1, 5, 16'h0050, 4'b0000, 24);
    check_frame(16'h0050, 4'b0000, 1'b1, -1, 16'h0, 4'b0, 24);

    phase = "fast_scan";
    load = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0000;
    step();
    load = 1'b0;
    enable2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("c%0d an", c), 32'(an2), 32'(~(4'b0001 << (c % 4)) & 4'hF));
      check($sformatf("c%0d seg", c), 32'(seg2), 32'(seg_tab[4 - (c % 4)]));
      check($sformatf("c%0d frame_done", c), 32'(frame_done2), 32'(c > 0 && (c % 4) == 0));
    end
    step();
    step();
    check("pre_reset_an", 32'(an2), 32'hD);
    reset2 = 1'b1;
    #1;
    check("async_an", 32'(an2), 32'hF);
    check("async_seg", 32'(seg2), 32'h7F);
    check("async_dp", 32'(dp2), 32'h1);
    check("async_frame_done", 32'(frame_done2), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
